bsg_piso_credit_fifo: RTL and testbench
=======================================

Name: bsg_piso_credit_fifo

Overview:
Width-conversion and buffering stage for response traffic: one wide word (els_p × width_p) in, width_p beats out, least-significant slice first. Beats pass through a buf_els_p-deep first-word-fall-through buffer. A free-slot counter is exported so an upstream host can manage credits. It sits between the manycore response FIFO and the narrow host (AXI-Lite) read-data path.

Parameters:
width_p, 32, width of one serial beat / output word
els_p, 4, beats per wide input word (≥1)
buf_els_p, 8, depth of output buffer in beats (≥2)

Ports:
clk_i  in  1  clock, all state updates on rising edge
reset_i  in  1  asynchronous, active-high reset
valid_i  in  1  wide input word valid
data_i  in  els_p*width_p  wide input word; slice k = bits [k*width_p +: width_p]
ready_and_o  out  1  converter can accept a wide word (valid-ready handshake)
v_o  out  1  buffer non-empty
data_o  out  width_p  head of buffer
yumi_i  in  1  consumer takes head; legal only when v_o=1
count_o  out  `BSG_WIDTH(buf_els_p)  number of free buffer slots

Behaviour:
- Reset (async assert, sync-released): converter empty, beat index 0, buffer empty. While reset_i=1: ready_and_o=0, v_o=0, count_o=buf_els_p, data_o don't-care.
- Converter states: EMPTY, SHIFT.
- EMPTY: ready_and_o=1. valid_i&ready_and_o latches data_i, index<=0, go SHIFT.
- SHIFT: ready_and_o=0 (no same-cycle reload on the last beat). Offer slice[index] to buffer each cycle.
- On each SHIFT enqueue: index++. If index==els_p-1, return to EMPTY instead.
- Sustained throughput is therefore 1 wide word per els_p+1 cycles when the buffer has space.
- els_p=1: SHIFT lasts one cycle per word.
- Buffer: circular, buf_els_p entries, read/write pointers wrap at buf_els_p (non-power-of-two depth supported).
- Enqueue when converter in SHIFT and buffer not full. Buffer ready = ~full, computed from the registered state only.
- When full: no enqueue, even if yumi_i is high the same cycle. The converter stalls holding its index.
- v_o = ~empty. data_o = entry at read pointer, combinationally visible the cycle after write (one-cycle fall-through latency from converter to v_o).
- Simultaneous enqueue and dequeue when neither full nor empty: both occur, occupancy unchanged.
- Full/empty tracked with an occupancy counter 0..buf_els_p.
- count_o = buf_els_p − occupancy, registered. +1 on yumi-only, −1 on enqueue-only, unchanged on both or neither.
- count_o never underflows or overflows under legal use.
- Input data_i only sampled at the handshake; later changes are ignored.

Optional Feature:
Macro BSG_PISO_CREDIT_FIFO_ASSERT_EN.
- Defined: simulation-only checks, each $error with %m:
  - yumi_i while v_o=0
  - valid_i X while not in reset
  - count_o > buf_els_p
  - width_p*els_p != width of data_i
- Undefined: no checks; RTL identical otherwise.

Decomposition:
- No new package types; use `BSG_WIDTH / `BSG_SAFE_CLOG2 from the shared defines include.
- Converter state encoding stays local (typedef enum in module).
- One sub-module is natural: bsg_piso_credit_fifo_buf (circular buffer plus occupancy/free counter, parameters width_p, els_p). The top holds only the converter FSM.

Test Plan:
- Reset: after reset_i pulse, expect ready_and_o=1, v_o=0, count_o=8. Assert reset mid-SHIFT: outputs return to these values immediately (async).
- Single word: data_i=0x44444444_33333333_22222222_11111111, yumi_i held 1.
  - Expect data_o sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - ready_and_o low for 4 cycles after the handshake.
- Fill: yumi_i=0, push 2 wide words. Expect count_o step 8→0, v_o=1, ready_and_o=1 after the 2nd word; a 3rd word is accepted, then its converter stalls.
- Full with yumi_i: pop one while full. Count goes 0→1, the stalled beat enqueues next cycle, count back to 0, beat order preserved.
- Steady state: valid_i=1, yumi_i=1 for 20 words. Expect a 4-of-5-cycle output duty, no reordering, and count_o never below 7.
- Wrap: els_p=3, buf_els_p=5. 10 words with random yumi_i produce all 30 beats in order; pointers wrap correctly.

Source files
------------

// File: rtl/bsg_piso_credit_fifo_pkg.sv
// bsg_piso_credit_fifo_pkg
//   Sizing helpers shared by the PISO credit FIFO files. They compute the same
//   values as the BSG_SAFE_CLOG2 / BSG_WIDTH defines, so this slice
//   elaborates on its own.
//   safe_clog2(x) : index width for x entries, never less than 1 bit.
//   bsg_width(x)  : bits needed to hold the value x itself (0..x).
package bsg_piso_credit_fifo_pkg;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int bsg_width(input int x);
    return $clog2(x + 1);
  endfunction

endpackage

// File: rtl/bsg_piso_credit_fifo_if.sv
// bsg_piso_credit_fifo_if
//   Bundles the wide-in handshake, the narrow-out handshake and the free-slot
//   credit count of bsg_piso_credit_fifo.
//   slave  : the FIFO side  (in: valid_i, data_i, yumi_i; out: ready_and_o, v_o, data_o, count_o)
//   master : host/upstream side, the mirror image.
interface bsg_piso_credit_fifo_if #(
  parameter int width_p   = 32,
  parameter int els_p     = 4,
  parameter int buf_els_p = 8
);
  logic                                                   valid_i;
  logic [els_p*width_p-1:0]                               data_i;
  logic                                                   ready_and_o;
  logic                                                   v_o;
  logic [width_p-1:0]                                     data_o;
  logic                                                   yumi_i;
  logic [bsg_piso_credit_fifo_pkg::bsg_width(buf_els_p)-1:0] count_o;

  modport slave (
    input  valid_i, data_i, yumi_i,
    output ready_and_o, v_o, data_o, count_o
  );

  modport master (
    output valid_i, data_i, yumi_i,
    input  ready_and_o, v_o, data_o, count_o
  );
endinterface

// File: rtl/bsg_piso_credit_fifo_buf.sv
// bsg_piso_credit_fifo_buf
//   Circular first-word-fall-through buffer of els_p beats with a registered
//   free-slot counter (the upstream credit count).
//   clk_i, reset_i : clock, async active-high reset
//   v_i, data_i    : beat offered for enqueue (taken when not full)
//   ready_o        : not full, from registered state only
//   v_o, data_o    : non-empty, head entry
//   yumi_i         : consumer takes the head
//   count_o        : free slots, els_p after reset
//   Optional checks: define BSG_PISO_CREDIT_FIFO_ASSERT_EN.
module bsg_piso_credit_fifo_buf
  import bsg_piso_credit_fifo_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p   = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          v_i,
  input  logic [width_p-1:0]            data_i,
  output logic                          ready_o,
  output logic                          v_o,
  output logic [width_p-1:0]            data_o,
  input  logic                          yumi_i,
  output logic [bsg_width(els_p)-1:0]   count_o
);
  localparam int ptr_w = safe_clog2(els_p);
  localparam int cnt_w = bsg_width(els_p);

  logic [width_p-1:0] r_mem [els_p];
  logic [ptr_w-1:0]   r_wptr, r_rptr;
  // Free-slot count doubles as the occupancy tracker: occupancy = els_p - r_free.
  logic [cnt_w-1:0]   r_free;
  logic               w_full, w_empty, w_enq, w_deq;

  // Explicit wrap so depths that are not a power of two work.
  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  assign w_full  = (r_free == '0);
  assign w_empty = (r_free == cnt_w'(els_p));
  // A full buffer refuses the beat even if the head leaves the same cycle.
  assign w_enq   = v_i & ~w_full;
  assign w_deq   = yumi_i & ~w_empty;

  assign ready_o = ~w_full;
  assign v_o     = ~w_empty;
  assign data_o  = r_mem[r_rptr];
  assign count_o = r_free;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_free <= cnt_w'(els_p);
    end else begin
      if (w_enq) r_wptr <= next_ptr(r_wptr);
      if (w_deq) r_rptr <= next_ptr(r_rptr);
      case ({w_enq, w_deq})
        2'b10:   r_free <= r_free - cnt_w'(1);
        2'b01:   r_free <= r_free + cnt_w'(1);
        default: r_free <= r_free;
      endcase
    end
  end

  // Storage carries no reset; contents are only visible behind v_o.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

`ifdef BSG_PISO_CREDIT_FIFO_ASSERT_EN
  always @(posedge clk_i) begin
    if (!reset_i && yumi_i && !v_o)
      $error("%m: yumi_i asserted while v_o=0");
    if (!reset_i && (int'(count_o) > els_p))
      $error("%m: count_o %0d exceeds depth %0d", count_o, els_p);
  end
`endif

endmodule

// File: rtl/bsg_piso_credit_fifo.sv
// bsg_piso_credit_fifo
//   Parallel-in serial-out converter feeding a credit-counted FWFT buffer.
//   A wide word (els_p x width_p) is taken on valid_i & ready_and_o and sent
//   out least-significant slice first, one beat per cycle while the buffer
//   has room. No reload on the last beat: one word per els_p+1 cycles.
//   clk_i, reset_i : clock, async active-high reset
//   io (slave)     : valid_i/data_i/ready_and_o wide input handshake,
//                    v_o/data_o/yumi_i narrow output, count_o free slots
//   Optional checks: define BSG_PISO_CREDIT_FIFO_ASSERT_EN.
module bsg_piso_credit_fifo
  import bsg_piso_credit_fifo_pkg::*;
#(
  parameter int width_p   = 32,
  parameter int els_p     = 4,
  parameter int buf_els_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bsg_piso_credit_fifo_if.slave  io
);
  localparam int idx_w = safe_clog2(els_p);

  typedef enum logic {e_empty, e_shift} state_e;

  state_e                         r_state, w_state_n;
  logic [idx_w-1:0]               r_idx, w_idx_n;
  logic [els_p-1:0][width_p-1:0]  r_data;
  logic                           w_ready, w_hs, w_buf_ready, w_enq;
  logic [width_p-1:0]             w_beat;

  // Ready is forced low while reset is held, not just after the edge.
  assign w_ready        = (r_state == e_empty) & ~reset_i;
  assign w_hs           = io.valid_i & w_ready;
  assign io.ready_and_o = w_ready;
  assign w_beat         = r_data[r_idx];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= e_empty;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
    end
  end

  // The wide word is sampled only at the handshake.
  always_ff @(posedge clk_i) begin
    if (w_hs) r_data <= io.data_i;
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_enq     = 1'b0;
    case (r_state)
      e_empty: begin
        if (w_hs) begin
          w_state_n = e_shift;
          w_idx_n   = '0;
        end
      end
      e_shift: begin
        // Stall holding the index while the buffer is full.
        w_enq = w_buf_ready;
        if (w_enq) begin
          if (r_idx == idx_w'(els_p - 1)) w_state_n = e_empty;
          else                            w_idx_n   = r_idx + idx_w'(1);
        end
      end
      default: w_state_n = e_empty;
    endcase
  end

  bsg_piso_credit_fifo_buf #(
    .width_p (width_p),
    .els_p   (buf_els_p)
  ) u_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (r_state == e_shift),
    .data_i  (w_beat),
    .ready_o (w_buf_ready),
    .v_o     (io.v_o),
    .data_o  (io.data_o),
    .yumi_i  (io.yumi_i),
    .count_o (io.count_o)
  );

`ifdef BSG_PISO_CREDIT_FIFO_ASSERT_EN
  always @(posedge clk_i) begin
    if (!reset_i && $isunknown(io.valid_i))
      $error("%m: valid_i is X outside reset");
    if ($bits(io.data_i) != width_p * els_p)
      $error("%m: data_i is %0d bits, expected %0d", $bits(io.data_i), width_p * els_p);
  end
`endif

endmodule

// File: tb/tb_bsg_piso_credit_fifo.sv
// tb_bsg_piso_credit_fifo
//   Directed bench for bsg_piso_credit_fifo: a 32x4 / depth-8 instance for
//   reset, single word, fill/stall, pop-while-full, steady state and async
//   reset, plus a 32x3 / depth-5 instance for pointer wrap.
module tb_bsg_piso_credit_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_yumi  = 1'b0;
  logic tb_yumi2 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bsg_piso_credit_fifo_if #(.width_p(32), .els_p(4), .buf_els_p(8)) bus ();
  bsg_piso_credit_fifo_if #(.width_p(32), .els_p(3), .buf_els_p(5)) bus2 ();

  // Consumer takes the head whenever it wants a beat and one is present.
  assign bus.yumi_i  = tb_yumi  & bus.v_o;
  assign bus2.yumi_i = tb_yumi2 & bus2.v_o;

  bsg_piso_credit_fifo #(.width_p(32), .els_p(4), .buf_els_p(8)) dut (
    .clk_i(clk), .reset_i(rst), .io(bus));

  bsg_piso_credit_fifo #(.width_p(32), .els_p(3), .buf_els_p(5)) dut_w (
    .clk_i(clk), .reset_i(rst), .io(bus2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat k of a tagged word, e.g. tag A, k 2 -> 32'hA2A2A2A2.
  function automatic logic [31:0] tbeat(input logic [3:0] tag, input int k);
    logic [7:0] b;
    b = {tag, 4'(k)};
    return {4{b}};
  endfunction

  function automatic logic [127:0] tword(input logic [3:0] tag);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) w[k*32 +: 32] = tbeat(tag, k);
    return w;
  endfunction

  function automatic logic [31:0] sbeat(input int n, input int k);
    return 32'h5EED_0000 | (32'(n) << 8) | 32'(k);
  endfunction

  function automatic logic [127:0] sword(input int n);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) w[k*32 +: 32] = sbeat(n, k);
    return w;
  endfunction

  function automatic logic [31:0] wbeat(input int n, input int k);
    return 32'hB000_0000 | (32'(n) << 8) | 32'(k);
  endfunction

  function automatic logic [95:0] wword(input int n);
    logic [95:0] w;
    for (int k = 0; k < 3; k++) w[k*32 +: 32] = wbeat(n, k);
    return w;
  endfunction

  // Offer one wide word and return just after its handshake edge.
  task automatic push_word(input logic [127:0] d);
    bit done;
    done = 0;
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    for (int i = 0; i < 40 && !done; i++) begin
      done = bus.ready_and_o;
      tick();
    end
    bus.valid_i = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL push_timeout: ready_and_o never rose, want 1");
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (bus.ready_and_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", bus.ready_and_o); end
    checks++; if (bus.v_o !== 1'b0)         begin errors++; $display("FAIL rst_v: got %0b want 0", bus.v_o); end
    checks++; if (bus.count_o !== 4'd8)     begin errors++; $display("FAIL rst_count: got %0d want 8", bus.count_o); end
    rst = 1'b0;
    #1;
    checks++; if (bus.ready_and_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %0b want 1", bus.ready_and_o); end
    checks++; if (bus.v_o !== 1'b0)         begin errors++; $display("FAIL post_rst_v: got %0b want 0", bus.v_o); end
    checks++; if (bus.count_o !== 4'd8)     begin errors++; $display("FAIL post_rst_count: got %0d want 8", bus.count_o); end
    checks++; if (bus2.count_o !== 3'd5)    begin errors++; $display("FAIL post_rst_count2: got %0d want 5", bus2.count_o); end
  endtask

  task automatic test_single();
    logic        exp_rdy [6] = '{0, 0, 0, 0, 1, 1};
    logic        exp_v   [6] = '{0, 1, 1, 1, 1, 0};
    logic [3:0]  exp_cnt [6] = '{8, 7, 7, 7, 7, 8};
    logic [31:0] exp_d   [6] = '{0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0};
    tb_yumi = 1'b1;
    push_word(128'h44444444_33333333_22222222_11111111);
    for (int c = 0; c < 6; c++) begin
      checks++; if (bus.ready_and_o !== exp_rdy[c]) begin errors++; $display("FAIL single_ready[%0d]: got %0b want %0b", c, bus.ready_and_o, exp_rdy[c]); end
      checks++; if (bus.v_o !== exp_v[c])           begin errors++; $display("FAIL single_v[%0d]: got %0b want %0b", c, bus.v_o, exp_v[c]); end
      checks++; if (bus.count_o !== exp_cnt[c])     begin errors++; $display("FAIL single_count[%0d]: got %0d want %0d", c, bus.count_o, exp_cnt[c]); end
      if (exp_v[c]) begin
        checks++; if (bus.data_o !== exp_d[c])      begin errors++; $display("FAIL single_data[%0d]: got %h want %h", c, bus.data_o, exp_d[c]); end
      end
      if (c < 5) tick();
    end
    tb_yumi = 1'b0;
  endtask

  task automatic test_fill();
    checks++; if (bus.count_o !== 4'd8) begin errors++; $display("FAIL fill_start: got %0d want 8", bus.count_o); end
    push_word(tword(4'hA));
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.count_o !== 4'(7 - i)) begin errors++; $display("FAIL fill_a_count[%0d]: got %0d want %0d", i, bus.count_o, 7 - i); end
    end
    push_word(tword(4'hB));
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.count_o !== 4'(3 - i)) begin errors++; $display("FAIL fill_b_count[%0d]: got %0d want %0d", i, bus.count_o, 3 - i); end
    end
    checks++; if (bus.v_o !== 1'b1)          begin errors++; $display("FAIL fill_v: got %0b want 1", bus.v_o); end
    checks++; if (bus.ready_and_o !== 1'b1)  begin errors++; $display("FAIL fill_ready: got %0b want 1", bus.ready_and_o); end
    checks++; if (bus.data_o !== 32'hA0A0A0A0) begin errors++; $display("FAIL fill_head: got %h want a0a0a0a0", bus.data_o); end
    push_word(tword(4'hC));
    tick();
    checks++; if (bus.ready_and_o !== 1'b0) begin errors++; $display("FAIL stall_ready: got %0b want 0", bus.ready_and_o); end
    checks++; if (bus.count_o !== 4'd0)     begin errors++; $display("FAIL stall_count: got %0d want 0", bus.count_o); end
  endtask

  task automatic test_full_yumi();
    logic [31:0] exp_q[$];
    int got;
    tb_yumi = 1'b1;
    tick();
    tb_yumi = 1'b0;
    checks++; if (bus.count_o !== 4'd1)        begin errors++; $display("FAIL pop_full_count: got %0d want 1", bus.count_o); end
    checks++; if (bus.data_o !== 32'hA1A1A1A1) begin errors++; $display("FAIL pop_full_head: got %h want a1a1a1a1", bus.data_o); end
    tick();
    checks++; if (bus.count_o !== 4'd0)        begin errors++; $display("FAIL refill_count: got %0d want 0", bus.count_o); end
    checks++; if (bus.ready_and_o !== 1'b0)    begin errors++; $display("FAIL refill_ready: got %0b want 0", bus.ready_and_o); end
    for (int k = 1; k < 4; k++) exp_q.push_back(tbeat(4'hA, k));
    for (int k = 0; k < 4; k++) exp_q.push_back(tbeat(4'hB, k));
    for (int k = 0; k < 4; k++) exp_q.push_back(tbeat(4'hC, k));
    got = 0;
    tb_yumi = 1'b1;
    for (int c = 0; c < 60 && got < 11; c++) begin
      if (bus.v_o) begin
        checks++; if (bus.data_o !== exp_q[got]) begin errors++; $display("FAIL drain[%0d]: got %h want %h", got, bus.data_o, exp_q[got]); end
        got++;
      end
      tick();
    end
    tb_yumi = 1'b0;
    tick();
    checks++; if (got != 11)            begin errors++; $display("FAIL drain_beats: got %0d want 11", got); end
    checks++; if (bus.v_o !== 1'b0)     begin errors++; $display("FAIL drain_v: got %0b want 0", bus.v_o); end
    checks++; if (bus.count_o !== 4'd8) begin errors++; $display("FAIL drain_count: got %0d want 8", bus.count_o); end
  endtask

  task automatic test_steady();
    int n, got, first, last, min_cnt;
    bit hs;
    n = 0; got = 0; first = -1; last = -1; min_cnt = 8;
    tb_yumi     = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = sword(0);
    for (int c = 0; c < 300 && got < 80; c++) begin
      if (int'(bus.count_o) < min_cnt) min_cnt = int'(bus.count_o);
      if (bus.v_o) begin
        checks++; if (bus.data_o !== sbeat(got / 4, got % 4)) begin errors++; $display("FAIL steady_data[%0d]: got %h want %h", got, bus.data_o, sbeat(got / 4, got % 4)); end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      hs = bus.valid_i && bus.ready_and_o;
      tick();
      if (hs) begin
        n++;
        if (n < 20) bus.data_i = sword(n);
        else        bus.valid_i = 1'b0;
      end
    end
    tb_yumi = 1'b0;
    checks++; if (got != 80)               begin errors++; $display("FAIL steady_beats: got %0d want 80", got); end
    checks++; if (last - first + 1 != 99)  begin errors++; $display("FAIL steady_span: got %0d want 99", last - first + 1); end
    checks++; if (min_cnt != 7)            begin errors++; $display("FAIL steady_min_count: got %0d want 7", min_cnt); end
  endtask

  task automatic test_wrap();
    int n, got, over;
    bit hs;
    n = 0; got = 0; over = 0;
    bus2.valid_i = 1'b1;
    bus2.data_i  = wword(0);
    for (int c = 0; c < 1000 && got < 30; c++) begin
      tb_yumi2 = 1'($urandom_range(0, 1));
      if (int'(bus2.count_o) > 5) over++;
      if (tb_yumi2 && bus2.v_o) begin
        checks++; if (bus2.data_o !== wbeat(got / 3, got % 3)) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", got, bus2.data_o, wbeat(got / 3, got % 3)); end
        got++;
      end
      hs = bus2.valid_i && bus2.ready_and_o;
      tick();
      if (hs) begin
        n++;
        if (n < 10) bus2.data_i = wword(n);
        else        bus2.valid_i = 1'b0;
      end
    end
    tb_yumi2 = 1'b0;
    tick(); tick();
    checks++; if (got != 30)             begin errors++; $display("FAIL wrap_beats: got %0d want 30", got); end
    checks++; if (over != 0)             begin errors++; $display("FAIL wrap_count_bound: got %0d cycles over 5, want 0", over); end
    checks++; if (bus2.count_o !== 3'd5) begin errors++; $display("FAIL wrap_count_end: got %0d want 5", bus2.count_o); end
    checks++; if (bus2.v_o !== 1'b0)     begin errors++; $display("FAIL wrap_v_end: got %0b want 0", bus2.v_o); end
  endtask

  task automatic test_async_reset();
    tb_yumi = 1'b0;
    push_word(tword(4'hD));
    tick();
    checks++; if (bus.ready_and_o !== 1'b0) begin errors++; $display("FAIL mid_ready: got %0b want 0", bus.ready_and_o); end
    checks++; if (bus.v_o !== 1'b1)         begin errors++; $display("FAIL mid_v: got %0b want 1", bus.v_o); end
    checks++; if (bus.count_o !== 4'd7)     begin errors++; $display("FAIL mid_count: got %0d want 7", bus.count_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.ready_and_o !== 1'b0) begin errors++; $display("FAIL arst_ready: got %0b want 0", bus.ready_and_o); end
    checks++; if (bus.v_o !== 1'b0)         begin errors++; $display("FAIL arst_v: got %0b want 0", bus.v_o); end
    checks++; if (bus.count_o !== 4'd8)     begin errors++; $display("FAIL arst_count: got %0d want 8", bus.count_o); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.ready_and_o !== 1'b1) begin errors++; $display("FAIL arst_rel_ready: got %0b want 1", bus.ready_and_o); end
    checks++; if (bus.v_o !== 1'b0)         begin errors++; $display("FAIL arst_rel_v: got %0b want 0", bus.v_o); end
    checks++; if (bus.count_o !== 4'd8)     begin errors++; $display("FAIL arst_rel_count: got %0d want 8", bus.count_o); end
  endtask

  initial begin
    bus.valid_i  = 1'b0;
    bus.data_i   = '0;
    bus2.valid_i = 1'b0;
    bus2.data_i  = '0;
    test_reset();
    test_single();
    test_fill();
    test_full_yumi();
    test_steady();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
